// File: rtl/y86_pkg.sv
// y86_pkg: instruction codes, register specifiers and write-back sequencer states.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RSP      = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {IDLE, WR_E, WR_M, DONE} state_t;

    function automatic logic is_invalid(input logic [3:0] icode);
        return icode > I_POPQ;
    endfunction
endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: combinational destination-register decode for write-back.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);
    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_CMOVXX:                 dstE = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:          dstE = rB;
            I_MRMOVQ:                 dstM = rA;
            I_CALL, I_RET, I_PUSHQ:   dstE = RSP;
            I_POPQ: begin
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: retires one write-back request as up to two register-file writes (E then M).
module wb_sequencer
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        wb_done,
    output logic        wb_err
);
    state_t      state;
    logic [3:0]  dst_e, dst_m;
    logic [3:0]  icode_q, dst_m_q;
    logic [63:0] val_m_q;

    wb_dst_decode u_dec (
        .icode(icode),
        .cnd(cnd),
        .rA(rA),
        .rB(rB),
        .dstE(dst_e),
        .dstM(dst_m)
    );

    // Outputs are loaded on the edge that enters each state, so they are valid for the whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_ready <= 1'b1;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_done  <= 1'b0;
            wb_err   <= 1'b0;
            icode_q  <= '0;
            dst_m_q  <= RNONE;
            val_m_q  <= '0;
        end else begin
            rf_we   <= 1'b0;
            wb_done <= 1'b0;
            wb_err  <= 1'b0;
            case (state)
                IDLE: if (wb_valid) begin
                    icode_q  <= icode;
                    dst_m_q  <= dst_m;
                    val_m_q  <= valM;
                    wb_ready <= 1'b0;
                    if (dst_e != RNONE) begin
                        state    <= WR_E;
                        rf_we    <= 1'b1;
                        rf_waddr <= dst_e;
                        rf_wdata <= valE;
                    end else if (dst_m != RNONE) begin
                        state    <= WR_M;
                        rf_we    <= 1'b1;
                        rf_waddr <= dst_m;
                        rf_wdata <= valM;
                    end else begin
                        state   <= DONE;
                        wb_done <= 1'b1;
                        wb_err  <= is_invalid(icode);
                    end
                end
                WR_E: if (dst_m_q != RNONE) begin
                    state    <= WR_M;
                    rf_we    <= 1'b1;
                    rf_waddr <= dst_m_q;
                    rf_wdata <= val_m_q;
                end else begin
                    state   <= DONE;
                    wb_done <= 1'b1;
                    wb_err  <= is_invalid(icode_q);
                end
                WR_M: begin
                    state   <= DONE;
                    wb_done <= 1'b1;
                    wb_err  <= is_invalid(icode_q);
                end
                DONE: begin
                    state    <= IDLE;
                    wb_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: directed and random write-back requests checked against a register-file model.
module tb_wb_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  icode = '0;
    logic        cnd = 1'b0;
    logic [3:0]  rA = '0;
    logic [3:0]  rB = '0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        wb_done;
    logic        wb_err;

    int tests = 0;
    int fails = 0;

    logic [3:0]  exp_a[$];
    logic [63:0] exp_d[$];
    logic        exp_err;
    logic [3:0]  last_a = '0;
    logic [63:0] last_d = '0;
    logic [63:0] mrf[16];
    logic [63:0] drf[16];

    wb_sequencer dut (
        .clk(clk),
        .rst(rst),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .icode(icode),
        .cnd(cnd),
        .rA(rA),
        .rB(rB),
        .valE(valE),
        .valM(valM),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .wb_done(wb_done),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ordered list of writes a request must produce, straight from the Y86 write-back rules.
    task automatic build(input logic [3:0] ic, input logic c, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] e, m;
        e = ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) ? b :
            (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        m = (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
        exp_a = {};
        exp_d = {};
        if (e != 4'hF) begin exp_a.push_back(e); exp_d.push_back(ve); end
        if (m != 4'hF) begin exp_a.push_back(m); exp_d.push_back(vm); end
        exp_err = ic > 4'hB;
    endtask

    task automatic scramble();
        wb_valid = 1'($urandom_range(0, 1));
        icode = 4'($urandom);
        cnd = 1'($urandom);
        rA = 4'($urandom);
        rB = 4'($urandom);
        valE = {$urandom, $urandom};
        valM = {$urandom, $urandom};
    endtask

    task automatic run_req(input logic [3:0] ic, input logic c, input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] ve, input logic [63:0] vm);
        int n;
        build(ic, c, a, b, ve, vm);
        n = exp_a.size();
        chk("ready_before", {63'd0, wb_ready}, 64'd1);
        wb_valid = 1'b1; icode = ic; cnd = c; rA = a; rB = b; valE = ve; valM = vm;
        @(posedge clk); #1;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k < n) begin
                last_a = exp_a[k];
                last_d = exp_d[k];
                mrf[exp_a[k]] = exp_d[k];
            end
            chk("rf_we", {63'd0, rf_we}, {63'd0, k < n});
            chk("rf_waddr", {60'd0, rf_waddr}, {60'd0, last_a});
            chk("rf_wdata", rf_wdata, last_d);
            chk("wb_done", {63'd0, wb_done}, {63'd0, k == n});
            chk("wb_err", {63'd0, wb_err}, {63'd0, k == n && exp_err});
            chk("ready_busy", {63'd0, wb_ready}, 64'd0);
            if (rf_we) drf[rf_waddr] = rf_wdata;
            scramble();
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("ready_idle", {63'd0, wb_ready}, 64'd1);
        chk("done_low", {63'd0, wb_done}, 64'd0);
        chk("we_idle", {63'd0, rf_we}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mrf[i] = '0; drf[i] = '0; end
        #12;
        chk("rst_ready", {63'd0, wb_ready}, 64'd1);
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_waddr", {60'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_done", {62'd0, wb_done, wb_err}, 64'd0);
        @(negedge clk) rst = 1'b0;

        run_req(4'h3, 1'b0, 4'h0, 4'h2, 64'h10, 64'h99);
        run_req(4'hB, 1'b0, 4'h3, 4'h0, 64'h100, 64'hAB);
        run_req(4'hB, 1'b0, 4'h4, 4'h0, 64'h100, 64'hAB);
        chk("rsp_final", drf[4], 64'hAB);
        run_req(4'h2, 1'b0, 4'h1, 4'h5, 64'h7, 64'h8);
        run_req(4'h2, 1'b1, 4'h1, 4'h5, 64'h7, 64'h8);
        chk("cmov_r5", drf[5], 64'h7);
        run_req(4'hE, 1'b1, 4'h1, 4'h2, 64'h55, 64'h66);
        run_req(4'h0, 1'b1, 4'h1, 4'h2, 64'h1, 64'h2);
        run_req(4'h1, 1'b1, 4'h3, 4'h4, 64'h3, 64'h4);
        run_req(4'h4, 1'b1, 4'h5, 4'h6, 64'h5, 64'h6);
        run_req(4'h7, 1'b1, 4'h7, 4'h8, 64'h7, 64'h8);
        run_req(4'h5, 1'b0, 4'h9, 4'h1, 64'hDEAD, 64'hBEEF);
        run_req(4'hA, 1'b0, 4'h9, 4'h1, 64'h200, 64'h300);
        for (int r = 0; r < 60; r++)
            run_req(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 16; i++) chk($sformatf("regfile_%0d", i), drf[i], mrf[i]);

        build(4'hB, 1'b0, 4'h3, 4'h0, 64'h100, 64'hAB);
        wb_valid = 1'b1; icode = 4'hB; rA = 4'h3; valE = 64'h100; valM = 64'hAB;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("abort_in_wr_e", {63'd0, rf_we}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", {63'd0, rf_we}, 64'd0);
        chk("abort_ready", {63'd0, wb_ready}, 64'd1);
        chk("abort_waddr", {60'd0, rf_waddr}, 64'd0);
        chk("abort_wdata", rf_wdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_abort_we", {63'd0, rf_we}, 64'd0);
            chk("post_abort_done", {63'd0, wb_done}, 64'd0);
            chk("post_abort_ready", {63'd0, wb_ready}, 64'd1);
        end
        last_a = '0;
        last_d = '0;
        run_req(4'h3, 1'b0, 4'h0, 4'h7, 64'h42, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 wb_valid  input  1  upstream holds a write-back request.
REQ-004 wb_ready  output  1  block can accept a request, high only in IDLE.
REQ-005 icode  input  4  instruction code of the request.
REQ-006 cnd  input  1  condition result, used for cmovxx only.
REQ-007 rA  input  4  register specifier A.
REQ-008 rB  input  4  register specifier B.
REQ-009 valE  input  64  execute-stage result.
REQ-010 valM  input  64  memory-stage result.
REQ-011 rf_we  output  1  register-file write enable, single write port.
REQ-012 rf_waddr  output  4  register-file write address.
REQ-013 rf_wdata  output  64  register-file write data.
REQ-014 wb_done  output  1  one-cycle pulse when the request has retired.
REQ-015 wb_err  output  1  one-cycle pulse coincident with wb_done for an invalid icode.

Function
REQ-016 The state machine SHALL have four states: IDLE, WR_E, WR_M and DONE; every output SHALL be registered.
REQ-017 Acceptance SHALL occur on a clock edge with wb_valid=1 and state IDLE; icode, cnd, rA, rB, valE and valM SHALL be captured only at that edge.
REQ-018 Register destinations SHALL be decoded from the captured values (RSP=4'h4, RNONE=4'hF):
  - cmovxx 2: dstE=rB if cnd=1, else RNONE.
  - irmovq 3, OPq 6: dstE=rB.
  - mrmovq 5: dstM=rA.
  - call 8, ret 9, pushq A: dstE=RSP.
  - popq B: dstE=RSP, dstM=rA.
  - All other destinations SHALL be RNONE.
REQ-019 Transition from IDLE on acceptance SHALL go to WR_E if dstE!=RNONE, else to WR_M if dstM!=RNONE, else to DONE.
REQ-020 In WR_E the outputs SHALL be rf_we=1, rf_waddr=dstE, rf_wdata=valE for exactly one cycle; the next state SHALL be WR_M if dstM!=RNONE, else DONE.
REQ-021 In WR_M the outputs SHALL be rf_we=1, rf_waddr=dstM, rf_wdata=valM for exactly one cycle; the next state SHALL be DONE.
REQ-022 In DONE, wb_done SHALL be 1 for one cycle; wb_err SHALL be 1 if the captured icode>4'hB; the next state SHALL be IDLE.
REQ-023 Latency from the accept edge to wb_done SHALL be 1 cycle for no writes, 2 cycles for one write and 3 cycles for two writes.
REQ-024 The E write SHALL always precede the M write, so for popq with rA=RSP the final RSP value SHALL be valM.
REQ-025 wb_valid while state is not IDLE SHALL be ignored, with wb_ready=0 and no capture.
REQ-026 rf_waddr and rf_wdata SHALL hold their last values whenever rf_we=0.
REQ-027 Invalid icode and icode 0, 1, 4, 7 SHALL produce no register write.
REQ-028 Back-to-back requests SHALL be supported; the earliest next acceptance SHALL be the edge at which DONE exits to IDLE plus one cycle.

Reset
REQ-029 While rst=1 the state SHALL be IDLE and the outputs SHALL be rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, wb_err=0, wb_ready=1; this SHALL apply asynchronously.
REQ-030 Reset mid-operation SHALL abort the request with no further writes and no wb_done pulse.

Structure
REQ-031 The package y86_pkg SHALL hold the icode constants, RSP, RNONE and the state enumeration.
REQ-032 Destination decode SHALL be the combinational sub-module wb_dst_decode (inputs icode, cnd, rA, rB; outputs dstE, dstM).

Verification
REQ-033 irmovq (icode 3, rB=2, valE=0x10) -> one cycle with rf_we=1, rf_waddr=2, rf_wdata=0x10; wb_done 2 cycles after accept.
REQ-034 popq (icode B, rA=3, valE=0x100, valM=0xAB) -> write 4<=0x100, then 3<=0xAB on consecutive cycles; wb_done at +3.
REQ-035 popq with rA=4 (valE=0x100, valM=0xAB) -> second write is 4<=0xAB; a model register file ends with RSP=0xAB.
REQ-036 cmovxx with cnd=0 (rB=5) -> no rf_we; wb_done at +1; the same request with cnd=1 and valE=0x7 -> 5<=0x7.
REQ-037 icode 0xE -> no write; wb_done and wb_err both pulse at +1.
REQ-038 Assert rst during WR_E of a popq -> rf_we drops immediately, no WR_M, no wb_done; wb_ready=1 after reset is released.
